// File: rtl/video_sync_h.sv
// Horizontal timing generator for the Pentagon/ATM video path: slot counter, line levels and one-shot strobes.
// Optional feature: define VIDEO_SYNC_H_SCANOUT_EN to enable the twice-per-line scanout_start strobe.
module video_sync_h #(
    parameter int unsigned HPERIOD       = 448,
    parameter int unsigned HBLNK_BEG     = 0,
    parameter int unsigned HSYNC_BEG     = 10,
    parameter int unsigned HSYNC_END     = 43,
    parameter int unsigned HBLNK_END     = 88,
    parameter int unsigned HINT_BEG      = 2,
    parameter int unsigned HPIX_BEG_PENT = 140,
    parameter int unsigned HPIX_END_PENT = 396,
    parameter int unsigned HPIX_BEG_ATM  = 108,
    parameter int unsigned HPIX_END_ATM  = 428,
    parameter int unsigned FETCH_LEAD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cend,
    input  logic       init,
    input  logic       mode_atm_n_pent,
    output logic [8:0] hcount,
    output logic       hblank,
    output logic       hsync,
    output logic       hpix,
    output logic       hsync_start,
    output logic       line_start,
    output logic       hint_start,
    output logic       fetch_start,
    output logic       fetch_end,
    output logic       scanout_start
);

    localparam int unsigned CW = 9;

    localparam logic [CW-1:0] S_LAST       = CW'(HPERIOD - 1);
    localparam logic [CW-1:0] S_HBLNK_BEG  = CW'(HBLNK_BEG);
    localparam logic [CW-1:0] S_HBLNK_END  = CW'(HBLNK_END);
    localparam logic [CW-1:0] S_HSYNC_BEG  = CW'(HSYNC_BEG);
    localparam logic [CW-1:0] S_HSYNC_END  = CW'(HSYNC_END);
    localparam logic [CW-1:0] S_HINT_BEG   = CW'(HINT_BEG);
    localparam logic [CW-1:0] S_PIXB_PENT  = CW'(HPIX_BEG_PENT);
    localparam logic [CW-1:0] S_PIXE_PENT  = CW'(HPIX_END_PENT);
    localparam logic [CW-1:0] S_PIXB_ATM   = CW'(HPIX_BEG_ATM);
    localparam logic [CW-1:0] S_PIXE_ATM   = CW'(HPIX_END_ATM);
    localparam logic [CW-1:0] S_FB_PENT    = CW'(HPIX_BEG_PENT - FETCH_LEAD);
    localparam logic [CW-1:0] S_FE_PENT    = CW'(HPIX_END_PENT - FETCH_LEAD);
    localparam logic [CW-1:0] S_FB_ATM     = CW'(HPIX_BEG_ATM - FETCH_LEAD);
    localparam logic [CW-1:0] S_FE_ATM     = CW'(HPIX_END_ATM - FETCH_LEAD);

    logic          mode_q;
    logic [CW-1:0] pix_beg;
    logic [CW-1:0] pix_end;
    logic [CW-1:0] fetch_beg_slot;
    logic [CW-1:0] fetch_end_slot;
    logic [CW-1:0] hcount_inc;
    logic          at_last;

    // Window slots follow the mode latched at the last line end, never the live input.
    always_comb begin
        pix_beg        = S_PIXB_PENT;
        pix_end        = S_PIXE_PENT;
        fetch_beg_slot = S_FB_PENT;
        fetch_end_slot = S_FE_PENT;
        if (mode_q) begin
            pix_beg        = S_PIXB_ATM;
            pix_end        = S_PIXE_ATM;
            fetch_beg_slot = S_FB_ATM;
            fetch_end_slot = S_FE_ATM;
        end
        at_last    = (hcount == S_LAST);
        hcount_inc = at_last ? '0 : hcount + CW'(1);
    end

    // Counter, levels and mode latch; everything is decided on the pre-update hcount.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            hblank <= 1'b0;
            hsync  <= 1'b0;
            hpix   <= 1'b0;
            mode_q <= 1'b0;
        end else if (init) begin
            hcount <= '0;
            hblank <= 1'b1;
            hsync  <= 1'b0;
            hpix   <= 1'b0;
            mode_q <= mode_atm_n_pent;
        end else if (cend) begin
            hcount <= hcount_inc;
            if (at_last) begin
                mode_q <= mode_atm_n_pent;
            end
            if (hcount == S_HBLNK_BEG) begin
                hblank <= 1'b1;
            end else if (hcount == S_HBLNK_END) begin
                hblank <= 1'b0;
            end
            if (hcount == S_HSYNC_BEG) begin
                hsync <= 1'b1;
            end else if (hcount == S_HSYNC_END) begin
                hsync <= 1'b0;
            end
            if (hcount == pix_beg) begin
                hpix <= 1'b1;
            end else if (hcount == pix_end) begin
                hpix <= 1'b0;
            end
        end
    end

    // Strobes are rebuilt every edge so they can never stretch past one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_start <= 1'b0;
            line_start  <= 1'b0;
            hint_start  <= 1'b0;
            fetch_start <= 1'b0;
            fetch_end   <= 1'b0;
        end else begin
            hsync_start <= 1'b0;
            line_start  <= 1'b0;
            hint_start  <= 1'b0;
            fetch_start <= 1'b0;
            fetch_end   <= 1'b0;
            if (cend && !init) begin
                hsync_start <= (hcount == S_HSYNC_BEG);
                line_start  <= (hcount == S_HBLNK_END);
                hint_start  <= (hcount == S_HINT_BEG);
                fetch_start <= (hcount == fetch_beg_slot);
                fetch_end   <= (hcount == fetch_end_slot);
            end
        end
    end

`ifdef VIDEO_SYNC_H_SCANOUT_EN
    localparam logic [CW-1:0] S_HALF = CW'(HPERIOD / 2);

    // Scandoubler read-side restart at the start and middle of every line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scanout_start <= 1'b0;
        end else begin
            scanout_start <= cend && !init && ((hcount == '0) || (hcount == S_HALF));
        end
    end
`else
    assign scanout_start = 1'b0;
`endif

endmodule

// File: tb/tb_video_sync_h.sv
// Directed self-checking bench for video_sync_h: line timing, mode latch, back-to-back cend, init and async reset.
module tb_video_sync_h;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cend = 1'b0;
    logic       init = 1'b0;
    logic       mode_atm_n_pent = 1'b0;
    logic [8:0] hcount;
    logic       hblank, hsync, hpix;
    logic       hsync_start, line_start, hint_start, fetch_start, fetch_end, scanout_start;

    int tests = 0;
    int fails = 0;

    // Per-line results gathered by run_line.
    int n_hblank, n_hsync, n_hpix, n_clks;
    int w_hs, w_ls, w_hi, w_fs, w_fe, w_so;
    int s_hs, s_ls, s_hi, s_fs, s_fe, s_so;

    video_sync_h dut (
        .clk(clk), .rst(rst), .cend(cend), .init(init), .mode_atm_n_pent(mode_atm_n_pent),
        .hcount(hcount), .hblank(hblank), .hsync(hsync), .hpix(hpix),
        .hsync_start(hsync_start), .line_start(line_start), .hint_start(hint_start),
        .fetch_start(fetch_start), .fetch_end(fetch_end), .scanout_start(scanout_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_strobes(input int pre);
        if (hsync_start)   begin w_hs++; s_hs = pre; end
        if (line_start)    begin w_ls++; s_ls = pre; end
        if (hint_start)    begin w_hi++; s_hi = pre; end
        if (fetch_start)   begin w_fs++; s_fs = pre; end
        if (fetch_end)     begin w_fe++; s_fe = pre; end
        if (scanout_start) begin w_so++; s_so += pre; end
    endtask

    // One full line of 448 cend edges spaced 'gap' clks; optional live mode flip at sw_slot.
    task automatic run_line(input int gap, input int sw_slot);
        int pre;
        n_hblank = 0; n_hsync = 0; n_hpix = 0; n_clks = 0;
        w_hs = 0; w_ls = 0; w_hi = 0; w_fs = 0; w_fe = 0; w_so = 0;
        s_hs = -1; s_ls = -1; s_hi = -1; s_fs = -1; s_fe = -1; s_so = 0;
        for (int i = 0; i < 448; i++) begin
            pre = int'(hcount);
            if (pre == sw_slot) mode_atm_n_pent = 1'b1;
            cend = 1'b1;
            clk_step();
            n_clks++;
            if (gap > 1) cend = 1'b0;
            if (hblank) n_hblank++;
            if (hsync)  n_hsync++;
            if (hpix)   n_hpix++;
            sample_strobes(pre);
            for (int g = 1; g < gap; g++) begin
                clk_step();
                n_clks++;
                sample_strobes(-100);
            end
        end
        cend = 1'b0;
    endtask

    task automatic check_line(input string ln, input int pix, input int fs, input int fe);
        check({ln, " hcount wrap"}, int'(hcount), 0);
        check({ln, " hblank slots"}, n_hblank, 88);
        check({ln, " hsync slots"}, n_hsync, 33);
        check({ln, " hpix slots"}, n_hpix, pix);
        check({ln, " hint slot"}, s_hi, 2);
        check({ln, " hsync_start slot"}, s_hs, 10);
        check({ln, " line_start slot"}, s_ls, 88);
        check({ln, " fetch_start slot"}, s_fs, fs);
        check({ln, " fetch_end slot"}, s_fe, fe);
        check({ln, " hint width"}, w_hi, 1);
        check({ln, " hsync_start width"}, w_hs, 1);
        check({ln, " line_start width"}, w_ls, 1);
        check({ln, " fetch_start width"}, w_fs, 1);
        check({ln, " fetch_end width"}, w_fe, 1);
`ifdef VIDEO_SYNC_H_SCANOUT_EN
        check({ln, " scanout count"}, w_so, 2);
        check({ln, " scanout slots"}, s_so, 224);
`else
        check({ln, " scanout count"}, w_so, 0);
`endif
    endtask

    initial begin
        int edges;
        bit seen;

        // Reset state
        repeat (3) clk_step();
        check("rst hcount", int'(hcount), 0);
        check("rst levels", int'({hblank, hsync, hpix}), 0);
        check("rst strobes", int'({hsync_start, line_start, hint_start, fetch_start, fetch_end, scanout_start}), 0);
        #2 rst = 1'b0;
        clk_step();
        check("post-rst hcount idle", int'(hcount), 0);

        // Pentagon lines, then a mid-line switch to ATM that must only affect the next line
        run_line(4, -1);
        check_line("pent1", 256, 124, 380);
        run_line(4, 200);
        check_line("pent2", 256, 124, 380);
        run_line(4, -1);
        check_line("atm1", 320, 92, 412);

        // Back-to-back cend: one slot per clk, 448-clk period
        run_line(1, -1);
        check_line("b2b", 320, 92, 412);
        check("b2b period clks", n_clks, 448);

        // init at slot 300 inside the pixel window, loading Pentagon mode
        mode_atm_n_pent = 1'b0;
        edges = 0;
        while (int'(hcount) != 300 && edges < 1000) begin
            cend = 1'b1; clk_step(); cend = 1'b0; clk_step();
            edges++;
        end
        check("reach 300", int'(hcount), 300);
        check("hpix before init", int'(hpix), 1);
        cend = 1'b1; init = 1'b1;
        clk_step();
        cend = 1'b0; init = 1'b0;
        check("init hcount", int'(hcount), 0);
        check("init hpix", int'(hpix), 0);
        check("init hblank", int'(hblank), 1);
        check("init strobes", int'({hsync_start, line_start, hint_start, fetch_start, fetch_end, scanout_start}), 0);
        edges = 0; seen = 1'b0;
        while (!seen && edges < 50) begin
            cend = 1'b1; clk_step(); cend = 1'b0;
            edges++;
            if (edges == 1) begin
                check("init slot0 hblank", int'(hblank), 1);
                check("init slot0 no hint", int'(hint_start), 0);
            end
            seen = hsync_start;
            repeat (3) clk_step();
        end
        check("init to hsync_start edges", edges, 11);

        // Asynchronous reset in the middle of hsync
        edges = 0;
        while (int'(hcount) != 20 && edges < 1000) begin
            cend = 1'b1; clk_step(); cend = 1'b0; clk_step();
            edges++;
        end
        check("reach 20", int'(hcount), 20);
        check("hsync at 20", int'(hsync), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst hcount", int'(hcount), 0);
        check("async rst levels", int'({hblank, hsync, hpix}), 0);
        check("async rst strobes", int'({hsync_start, line_start, hint_start, fetch_start, fetch_end, scanout_start}), 0);
        #2 rst = 1'b0;
        cend = 1'b1; clk_step(); cend = 1'b0;
        check("restart hcount", int'(hcount), 1);
        check("restart hblank", int'(hblank), 1);
        clk_step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
